// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
//   Control bundle between the multi-cycle sequencing controller and the
//   shared RV64 datapath / unified memory port.
//
//   Datapath -> controller : Opcode (IR[6:0]), Zero (ALU flag), mem_ready
//   Controller -> datapath : PCWrite, IRWrite, IorD, MemRead, MemWrite,
//                            MemtoReg, RegWrite, ALUSrcA, ALUSrcB[1:0],
//                            ALUOp[1:0], PCSrc
//
//   modport master : the controller
//   modport slave  : the datapath / memory side
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic [6:0] Opcode;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       PCSrc;

  modport master (
    input  Opcode, Zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc
  );

  modport slave (
    output Opcode, Zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencing controller for the RV64 subset (R-type, ld, sd,
//   beq, addi). Steps one instruction through FETCH / DECODE / EXEC / MEM /
//   WB over 3-5 cycles sharing one ALU and one memory port. Memory states
//   stall on mem_ready. Includes free-running cycle and retired-instruction
//   counters (wrap modulo 2^CNT_W).
//
//   Parameters
//     CNT_W         : width of cycle_cnt / instret_cnt
//   Ports
//     clk           : system clock, rising edge
//     reset_n       : asynchronous active-low reset
//     bus           : control bundle (multicycle_ctrl_if.master)
//     illegal_instr : sticky illegal-opcode flag (0 unless ILLEGAL_TRAP_EN)
//     cycle_cnt     : cycles since reset
//     instret_cnt   : instructions retired
//
//   Build option
//     ILLEGAL_TRAP_EN : unlisted opcodes enter a terminal TRAP state and set
//                       illegal_instr. Undefined: unlisted opcodes retire
//                       from DECODE as a NOP.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  multicycle_ctrl_if.master bus,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t state, state_nxt;

  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_src;
  logic       retire;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and Moore output decode. The only input-dependent outputs are
  // the FETCH completion strobes (mem_ready) and PCWrite in BRANCH (Zero).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    pc_src     = 1'b0;
    retire     = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = SRCB_IMM;
        case (bus.Opcode)
          OP_R:         state_nxt = S_EXEC_R;
          OP_I:         state_nxt = S_EXEC_I;
          OP_LD, OP_SD: state_nxt = S_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_nxt = S_TRAP;
`else
            retire    = 1'b1;
            state_nxt = S_FETCH;
`endif
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_FUNCT;
        state_nxt = S_WB_ALU;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = S_WB_ALU;
      end

      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (bus.Opcode == OP_SD) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_nxt = S_WB_MEM;
        end
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end

      S_WB_ALU: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        pc_write  = bus.Zero;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_nxt = S_TRAP;
      end
`endif

      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  assign bus.PCWrite  = pc_write;
  assign bus.IRWrite  = ir_write;
  assign bus.IorD     = i_or_d;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.RegWrite = reg_write;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.PCSrc    = pc_src;

  // ---------------------------------------------------------------------------
  // Illegal-instruction flag
  // ---------------------------------------------------------------------------
`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_instr <= 1'b0;
    end else if ((state == S_DECODE) && (state_nxt == S_TRAP)) begin
      illegal_instr <= 1'b1;
    end
  end
`else
  assign illegal_instr = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Performance counters, wrapping modulo 2^CNT_W
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed table of per-cycle vectors covering add, ld (with stalls),
//   sd (with stalls), beq taken / not taken and addi, followed by hand-written
//   sequences for the illegal opcode, reset during MEM_WR and counter wrap on
//   a CNT_W = 4 instance.
//   Control vector packing:
//   {PCWrite,IRWrite,IorD,MemRead,MemWrite,MemtoReg,RegWrite,ALUSrcA,
//    ALUSrcB[1:0],ALUOp[1:0],PCSrc}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ILL  = 7'b1111111;

  localparam logic [12:0] C_FETCH_WAIT = 13'b0_0_0_1_0_0_0_0_01_00_0;
  localparam logic [12:0] C_FETCH_GO   = 13'b1_1_0_1_0_0_0_0_01_00_0;
  localparam logic [12:0] C_DECODE     = 13'b0_0_0_0_0_0_0_0_10_00_0;
  localparam logic [12:0] C_EXEC_R     = 13'b0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [12:0] C_EXEC_I     = 13'b0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [12:0] C_ADDR       = 13'b0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [12:0] C_MEM_RD     = 13'b0_0_1_1_0_0_0_0_00_00_0;
  localparam logic [12:0] C_MEM_WR     = 13'b0_0_1_0_1_0_0_0_00_00_0;
  localparam logic [12:0] C_WB_ALU     = 13'b0_0_0_0_0_0_1_0_00_00_0;
  localparam logic [12:0] C_WB_MEM     = 13'b0_0_0_0_0_1_1_0_00_00_0;
  localparam logic [12:0] C_BR_T       = 13'b1_0_0_0_0_0_0_1_00_01_1;
  localparam logic [12:0] C_BR_N       = 13'b0_0_0_0_0_0_0_1_00_01_1;
  localparam logic [12:0] C_IDLE       = 13'b0_0_0_0_0_0_0_0_00_00_0;

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        mr;
    logic [12:0] ctrl;
    logic [31:0] inst;
  } vec_t;

  localparam int NV = 28;

  logic        clk;
  logic        reset_n;
  logic        reset2_n;
  logic        illegal_instr;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic        illegal2;
  logic [3:0]  cycle2;
  logic [3:0]  instret2;

  int n_cmp;
  int n_fail;

  vec_t vecs [NV];

  multicycle_ctrl_if bus ();
  multicycle_ctrl_if bus2 ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .illegal_instr(illegal_instr),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk          (clk),
    .reset_n      (reset2_n),
    .bus          (bus2),
    .illegal_instr(illegal2),
    .cycle_cnt    (cycle2),
    .instret_cnt  (instret2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] ctrl_of();
    return {bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.PCSrc};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [12:0] ctrl,
                           input logic [31:0] cyc, input logic [31:0] inst,
                           input logic ill);
    check({tag, " ctrl"}, 64'(ctrl_of()), 64'(ctrl));
    check({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(cyc));
    check({tag, " instret_cnt"}, 64'(instret_cnt), 64'(inst));
    check({tag, " illegal_instr"}, 64'(illegal_instr), 64'(ill));
  endtask

  task automatic drive(input logic [6:0] op, input logic z, input logic mr);
    bus.Opcode    = op;
    bus.Zero      = z;
    bus.mem_ready = mr;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    vecs[0]  = '{OP_ADD,  1'b0, 1'b1, C_FETCH_GO,   32'd0};
    vecs[1]  = '{OP_ADD,  1'b1, 1'b0, C_DECODE,     32'd0};
    vecs[2]  = '{OP_ADD,  1'b1, 1'b0, C_EXEC_R,     32'd0};
    vecs[3]  = '{OP_ADD,  1'b0, 1'b0, C_WB_ALU,     32'd0};
    vecs[4]  = '{OP_LD,   1'b0, 1'b1, C_FETCH_GO,   32'd1};
    vecs[5]  = '{OP_LD,   1'b0, 1'b1, C_DECODE,     32'd1};
    vecs[6]  = '{OP_LD,   1'b0, 1'b1, C_ADDR,       32'd1};
    vecs[7]  = '{OP_LD,   1'b0, 1'b0, C_MEM_RD,     32'd1};
    vecs[8]  = '{OP_LD,   1'b0, 1'b0, C_MEM_RD,     32'd1};
    vecs[9]  = '{OP_LD,   1'b0, 1'b1, C_MEM_RD,     32'd1};
    vecs[10] = '{OP_LD,   1'b0, 1'b0, C_WB_MEM,     32'd1};
    vecs[11] = '{OP_SD,   1'b0, 1'b0, C_FETCH_WAIT, 32'd2};
    vecs[12] = '{OP_SD,   1'b0, 1'b1, C_FETCH_GO,   32'd2};
    vecs[13] = '{OP_SD,   1'b0, 1'b1, C_DECODE,     32'd2};
    vecs[14] = '{OP_SD,   1'b0, 1'b1, C_ADDR,       32'd2};
    vecs[15] = '{OP_SD,   1'b0, 1'b0, C_MEM_WR,     32'd2};
    vecs[16] = '{OP_SD,   1'b0, 1'b1, C_MEM_WR,     32'd2};
    vecs[17] = '{OP_BEQ,  1'b0, 1'b1, C_FETCH_GO,   32'd3};
    vecs[18] = '{OP_BEQ,  1'b1, 1'b1, C_DECODE,     32'd3};
    vecs[19] = '{OP_BEQ,  1'b1, 1'b1, C_BR_T,       32'd3};
    vecs[20] = '{OP_BEQ,  1'b0, 1'b1, C_FETCH_GO,   32'd4};
    vecs[21] = '{OP_BEQ,  1'b0, 1'b1, C_DECODE,     32'd4};
    vecs[22] = '{OP_BEQ,  1'b0, 1'b1, C_BR_N,       32'd4};
    vecs[23] = '{OP_ADDI, 1'b0, 1'b1, C_FETCH_GO,   32'd5};
    vecs[24] = '{OP_ADDI, 1'b0, 1'b1, C_DECODE,     32'd5};
    vecs[25] = '{OP_ADDI, 1'b0, 1'b0, C_EXEC_I,     32'd5};
    vecs[26] = '{OP_ADDI, 1'b0, 1'b1, C_WB_ALU,     32'd5};
    vecs[27] = '{OP_ILL,  1'b0, 1'b1, C_FETCH_GO,   32'd6};

    // Reset state
    reset_n  = 1'b0;
    reset2_n = 1'b0;
    bus2.Opcode    = OP_ADD;
    bus2.Zero      = 1'b0;
    bus2.mem_ready = 1'b0;
    drive(OP_ADD, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check_all("reset", C_FETCH_WAIT, 32'd0, 32'd0, 1'b0);

    // Table-driven instruction stream
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].op, vecs[i].zero, vecs[i].mr);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ctrl, 32'(i), vecs[i].inst, 1'b0);
    end

    // Illegal opcode in DECODE
    @(negedge clk);
    drive(OP_ILL, 1'b0, 1'b1);
    #1;
    check_all("ill decode", C_DECODE, 32'd28, 32'd6, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(OP_ADD, 1'b1, 1'b1);
      #1;
      check_all($sformatf("trap%0d", k), C_IDLE, 32'(29 + k), 32'd6, 1'b1);
    end
`else
    @(negedge clk);
    drive(OP_ADD, 1'b0, 1'b1);
    #1;
    check_all("ill nop fetch", C_FETCH_GO, 32'd29, 32'd7, 1'b0);
    @(negedge clk);
    #1;
    check_all("ill nop decode", C_DECODE, 32'd30, 32'd7, 1'b0);
`endif

    // Reset asserted during MEM_WR
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    drive(OP_SD, 1'b0, 1'b1);
    #1;
    check_all("rst sd fetch", C_FETCH_GO, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    check_all("rst sd decode", C_DECODE, 32'd1, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    check_all("rst sd addr", C_ADDR, 32'd2, 32'd0, 1'b0);
    @(negedge clk);
    drive(OP_SD, 1'b0, 1'b0);
    #1;
    check_all("rst sd memwr", C_MEM_WR, 32'd3, 32'd0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check_all("rst async", C_FETCH_WAIT, 32'd0, 32'd0, 1'b0);
    drive(OP_SD, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check_all("rst held", C_FETCH_GO, 32'd0, 32'd0, 1'b0);
    drive(OP_SD, 1'b0, 1'b0);
    reset_n = 1'b1;
    #1;
    check_all("rst release", C_FETCH_WAIT, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    check_all("rst after", C_FETCH_WAIT, 32'd1, 32'd0, 1'b0);

    // Counter wrap on the CNT_W = 4 instance (stalled in FETCH)
    @(negedge clk);
    reset2_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("wrap cyc k=%0d", k), 64'(cycle2), 64'(k % 16));
    end
    check("wrap instret", 64'(instret2), 64'd0);
    check("wrap illegal", 64'(illegal2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
